// File: rtl/freq_mon_pkg.sv
// Shared constants and state encoding for the slow-clock frequency monitor.
// The defaults describe a divider that toggles every 250000 cycles of the fast clock.
package freq_mon_pkg;

   localparam int DEF_CNT_W       = 20;
   localparam int DEF_HALF_PERIOD = 250000;
   localparam int DEF_EXP_PERIOD  = 2 * DEF_HALF_PERIOD;
   localparam int DEF_TOL         = 16;
   localparam int DEF_LOCK_CNT    = 4;
   localparam int DEF_TIMEOUT_CYC = 1000000;
   localparam int LOCK_W          = 4;

   typedef enum logic {
      S_ACQ  = 1'b0,
      S_MEAS = 1'b1
   } state_e;

endpackage

// File: rtl/sync_rise_det.sv
// Synchronises the slow input into the fast clock domain and flags genuine rising edges.
// An edge is only accepted after a real low level has been seen following reset.
module sync_rise_det (
   input  logic clk_in,
   input  logic reset,
   input  logic sig_i,
   output logic rise_o
);

   logic s1_q, s2_q, s3_q;
   logic primed_q, armed_q;

   // primed_q marks that s1_q holds a real sample rather than its reset value
   always_ff @(posedge clk_in) begin
      if (reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         primed_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         s1_q     <= sig_i;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         primed_q <= 1'b1;
         armed_q  <= armed_q | (primed_q & ~s1_q & ~s2_q);
      end
   end

   assign rise_o = s2_q & ~s3_q & armed_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Measures the period of a slow square wave in fast-clock cycles, reports each period,
// declares lock after consecutive in-tolerance periods and flags loss of signal.
//
// state  | meaning
// S_ACQ  | waiting for a reference rising edge, counter held at 0
// S_MEAS | counting cycles between rising edges
module clk_freq_monitor
   import freq_mon_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
   parameter int TOL         = DEF_TOL,
   parameter int LOCK_CNT    = DEF_LOCK_CNT,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             in_range,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W:0]    LO_BOUND = (CNT_W+1)'(EXP_PERIOD - TOL);
   localparam logic [CNT_W:0]    HI_BOUND = (CNT_W+1)'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    period_q, period_d;
   logic                pv_q, pv_d;
   logic                in_range_q, in_range_d;
   logic                locked_q, locked_d;
   logic                timeout_q, timeout_d;
   logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic                rise;
   logic [CNT_W:0]      meas;
   logic                meas_ok;
   logic                cnt_last;

   sync_rise_det u_sync (
      .clk_in (clk_in),
      .reset  (reset),
      .sig_i  (sig_in),
      .rise_o (rise)
   );

   // One extra bit so a period equal to 2**CNT_W still compares correctly
   assign meas     = {1'b0, count_q} + (CNT_W+1)'(1);
   assign meas_ok  = (meas >= LO_BOUND) && (meas <= HI_BOUND);
   assign cnt_last = (count_q == CNT_LAST);

   always_ff @(posedge clk_in) begin
      if (reset) state_q <= S_ACQ;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ACQ:   if (rise) state_d = S_MEAS;
         S_MEAS:  if (!rise && cnt_last) state_d = S_ACQ;
         default: state_d = S_ACQ;
      endcase
   end

   always_comb begin
      count_d    = count_q;
      period_d   = period_q;
      pv_d       = 1'b0;
      in_range_d = in_range_q;
      locked_d   = locked_q;
      timeout_d  = 1'b0;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         S_ACQ: count_d = '0;
         S_MEAS: begin
            if (rise) begin
               period_d   = meas[CNT_W-1:0];
               pv_d       = 1'b1;
               in_range_d = meas_ok;
               count_d    = '0;
               if (meas_ok) begin
                  lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
                  locked_d   = (lock_cnt_d == LOCK_MAX);
               end else begin
                  lock_cnt_d = '0;
                  locked_d   = 1'b0;
               end
            end else if (cnt_last) begin
               timeout_d  = 1'b1;
               locked_d   = 1'b0;
               lock_cnt_d = '0;
               count_d    = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: count_d = '0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         count_q    <= '0;
         period_q   <= '0;
         pv_q       <= 1'b0;
         in_range_q <= 1'b0;
         locked_q   <= 1'b0;
         timeout_q  <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         period_q   <= period_d;
         pv_q       <= pv_d;
         in_range_q <= in_range_d;
         locked_q   <= locked_d;
         timeout_q  <= timeout_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign period       = period_q;
   assign period_valid = pv_q;
   assign in_range     = in_range_q;
   assign locked       = locked_q;
   assign timeout      = timeout_q;

endmodule
